// File: rtl/spi_note_sender_pkg.sv
// Shared constants for the SPI note-command link: status bytes, FSM encoding, frame lengths.
// Also imported by the receiver side of the link.
package spi_note_sender_pkg;

    localparam logic [7:0] NOTEON_BYTE  = 8'h90;
    localparam logic [7:0] NOTEOFF_BYTE = 8'h80;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] SHIFT_LO = 3'd1;
    localparam logic [2:0] SHIFT_HI = 3'd2;
    localparam logic [2:0] GAP      = 3'd3;
    localparam logic [2:0] HOLD     = 3'd4;

    localparam logic [2:0] NBYTES_NOTEON  = 3'd4;
    localparam logic [2:0] NBYTES_NOTEOFF = 3'd2;

endpackage

// File: rtl/spi_note_sender_byte_shifter.sv
// Shifts one byte out MSB first in SPI mode 0; i_start loads the byte and drives bit 7 next cycle.
// Latency: 16*CLK_DIV cycles per byte; o_done is high during the last of them. No backpressure.
module spi_byte_shifter
    import spi_note_sender_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_start,
    input  logic [7:0] i_byte,
    output logic       o_sclk,
    output logic       o_mosi,
    output logic       o_done
);

    localparam int DIV_W = $clog2(CLK_DIV);

    logic [2:0]       r_phase;
    logic [DIV_W-1:0] r_div;
    logic [2:0]       r_bit;
    logic [7:0]       r_sh;
    logic             r_sclk;
    logic             w_div_end;

    assign w_div_end = (r_div == DIV_W'(CLK_DIV - 1));
    assign o_done    = (r_phase == SHIFT_HI) && w_div_end && (r_bit == 3'd0);
    assign o_sclk    = r_sclk;
    assign o_mosi    = r_sh[7];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_phase <= IDLE;
            r_div   <= '0;
            r_bit   <= 3'd0;
            r_sh    <= 8'h00;
            r_sclk  <= 1'b0;
        end else if (i_start) begin
            r_phase <= SHIFT_LO;
            r_div   <= '0;
            r_bit   <= 3'd7;
            r_sh    <= i_byte;
            r_sclk  <= 1'b0;
        end else if (r_phase != IDLE) begin
            if (!w_div_end) begin
                r_div <= r_div + 1'b1;
            end else begin
                r_div <= '0;
                if (r_phase == SHIFT_LO) begin
                    r_phase <= SHIFT_HI;
                    r_sclk  <= 1'b1;
                end else if (r_bit == 3'd0) begin
                    // mosi returns low once the byte is finished
                    r_phase <= IDLE;
                    r_sh    <= 8'h00;
                    r_sclk  <= 1'b0;
                end else begin
                    r_phase <= SHIFT_LO;
                    r_bit   <= r_bit - 3'd1;
                    r_sh    <= {r_sh[6:0], 1'b0};
                    r_sclk  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/spi_note_sender.sv
// SPI master framing note-on (4 bytes) / note-off (2 bytes) commands, one CS-framed transfer each.
// Latency: CS low the cycle after accept; frame lasts N*16*CLK_DIV + (N-1)*GAP_CYCLES + CLK_DIV cycles.
// Backpressure: cmd_ready low for the whole frame; nothing is queued.
module spi_note_sender
    import spi_note_sender_pkg::*;
#(
    parameter int         CLK_DIV    = 4,
    parameter int         GAP_CYCLES = 8,
    parameter logic [7:0] NOTEON     = NOTEON_BYTE,
    parameter logic [7:0] NOTEOFF    = NOTEOFF_BYTE
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_note_status,
    input  logic [7:0] cmd_voice_index,
    input  logic [6:0] cmd_midi_note,
    input  logic [6:0] cmd_velocity,
    output logic       SPI_sclk,
    output logic       SPI_mosi,
    output logic       SPI_cs_n,
    output logic       busy,
    output logic       frame_done
);

    logic [2:0]  r_state;
    logic        r_cs_n;
    logic        r_ready;
    logic        r_done;
    logic        r_on;
    logic [7:0]  r_voice;
    logic [6:0]  r_note;
    logic [6:0]  r_vel;
    logic [1:0]  r_idx;
    logic [15:0] r_cnt;

    logic        w_accept;
    logic        w_gap_end;
    logic        w_hold_end;
    logic        w_start;
    logic        w_last_byte;
    logic        w_sh_done;
    logic [2:0]  w_nbytes;
    logic [1:0]  w_next_idx;
    logic [7:0]  w_byte;

    assign w_accept    = cmd_valid & r_ready;
    assign w_gap_end   = (r_state == GAP)  && (r_cnt == 16'(GAP_CYCLES - 1));
    assign w_hold_end  = (r_state == HOLD) && (r_cnt == 16'(CLK_DIV - 1));
    assign w_start     = w_accept | w_gap_end;
    assign w_nbytes    = r_on ? NBYTES_NOTEON : NBYTES_NOTEOFF;
    assign w_last_byte = ({1'b0, r_idx} == (w_nbytes - 3'd1));
    assign w_next_idx  = r_idx + 2'd1;

    // Byte 0 comes straight from the inputs so it can start on the accept edge.
    always_comb begin
        w_byte = 8'h00;
        if (r_state == IDLE) begin
            w_byte = cmd_note_status ? NOTEON : NOTEOFF;
        end else begin
            case (w_next_idx)
                2'd1:    w_byte = r_voice;
                2'd2:    w_byte = {1'b0, r_note};
                2'd3:    w_byte = {1'b0, r_vel};
                default: w_byte = r_on ? NOTEON : NOTEOFF;
            endcase
        end
    end

    spi_byte_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk     (clk),
        .reset_n (reset_n),
        .i_start (w_start),
        .i_byte  (w_byte),
        .o_sclk  (SPI_sclk),
        .o_mosi  (SPI_mosi),
        .o_done  (w_sh_done)
    );

    // SHIFT_LO here means "byte in flight"; the LO/HI phases are sequenced by the shifter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cs_n  <= 1'b1;
            r_ready <= 1'b0;
            r_done  <= 1'b0;
            r_on    <= 1'b0;
            r_voice <= 8'h00;
            r_note  <= 7'h00;
            r_vel   <= 7'h00;
            r_idx   <= 2'd0;
            r_cnt   <= 16'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_on    <= cmd_note_status;
                        r_voice <= cmd_voice_index;
                        r_note  <= cmd_midi_note;
                        r_vel   <= cmd_velocity;
                        r_idx   <= 2'd0;
                        r_cs_n  <= 1'b0;
                        r_ready <= 1'b0;
                        r_state <= SHIFT_LO;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                SHIFT_LO: begin
                    if (w_sh_done) begin
                        r_cnt   <= 16'd0;
                        r_state <= w_last_byte ? HOLD : GAP;
                    end
                end
                GAP: begin
                    if (w_gap_end) begin
                        r_idx   <= w_next_idx;
                        r_state <= SHIFT_LO;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                HOLD: begin
                    if (w_hold_end) begin
                        r_cs_n  <= 1'b1;
                        r_ready <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cmd_ready  = r_ready;
    assign SPI_cs_n   = r_cs_n;
    assign busy       = (r_state != IDLE);
    assign frame_done = r_done;

endmodule
